// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/avg pooling over a raster-scanned CH-channel feature map.
// Latency: 1 cycle from acceptance of the odd-x/odd-y pixel to data_out_valid.
// Backpressure: none; one pixel accepted per data_in_valid, gaps hold all state.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous reset, active-high (legacy name)
//   data_in        CH samples of DATA_W bits, channel k at [(k+1)*DATA_W-1 : k*DATA_W]
//   data_in_valid  pixel present this cycle
//   data_out       pooled pixel, same channel packing, held between output events
//   data_out_valid single-cycle pulse per pooled pixel
//   frame_done     pulses with the last pooled pixel of a frame
module pool2x2_stream #(
    parameter int DATA_W = 32,
    parameter int CH     = 3,
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26,
    parameter int SIGNED = 1,
    parameter int MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] data_in,
    input  logic                 data_in_valid,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 frame_done
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int LB_D = IMG_W / 2;
    localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;
    // Average mode keeps the full-precision pair sum; max mode needs no growth.
    localparam int PW   = (MODE != 0) ? DATA_W + 1 : DATA_W;
    // Working width: room for a 4-sample sum plus sign.
    localparam int EW   = DATA_W + 2;
    localparam int SH   = (MODE != 0) ? 2 : 0;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    // Last pooled window of a frame; odd dimensions drop the trailing column/row.
    localparam logic [XW-1:0] X_FD   = XW'(2 * (IMG_W / 2) - 1);
    localparam logic [YW-1:0] Y_FD   = YW'(2 * (IMG_H / 2) - 1);

    logic [XW-1:0]                x_q, x_d;
    logic [YW-1:0]                y_q, y_d;
    logic [CH-1:0][DATA_W-1:0]    h_q, h_d;
    logic [CH-1:0][DATA_W-1:0]    out_q, out_d;
    logic                         out_vld_q, out_vld_d;
    logic                         fd_q, fd_d;

    logic [CH-1:0][PW-1:0]        lb_q [LB_D];
    logic [CH-1:0][PW-1:0]        lb_rd;
    logic [CH-1:0][PW-1:0]        p_w;
    logic [CH-1:0][DATA_W-1:0]    r_w;
    logic [CH-1:0][DATA_W-1:0]    din;
    logic [LBW-1:0]               lb_idx;
    logic                         lb_we;

    assign din    = data_in;
    assign lb_idx = LBW'(x_q >> 1);
    assign lb_rd  = lb_q[lb_idx];

    // Sign- or zero-extend into the working width so a single signed compare
    // and a single adder serve both SIGNED settings.
    function automatic logic [EW-1:0] ext_d(input logic [DATA_W-1:0] v);
        return (SIGNED != 0) ? {{2{v[DATA_W-1]}}, v} : {2'b00, v};
    endfunction

    function automatic logic [EW-1:0] ext_l(input logic [PW-1:0] v);
        return (SIGNED != 0) ? {{(EW-PW){v[PW-1]}}, v} : {{(EW-PW){1'b0}}, v};
    endfunction

    function automatic logic [EW-1:0] op(input logic [EW-1:0] a, input logic [EW-1:0] b);
        if (MODE != 0) begin
            return a + b;
        end
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            p_w[c] = PW'(op(ext_d(h_q[c]), ext_d(din[c])));
            // Average: keep bits [EW-1:2] of the 4-sample sum, i.e. floor(sum/4).
            r_w[c] = DATA_W'(op(ext_l(lb_rd[c]), op(ext_d(h_q[c]), ext_d(din[c]))) >> SH);
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        h_d       = h_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        fd_d      = 1'b0;
        lb_we     = 1'b0;
        if (data_in_valid) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            // With odd IMG_W the last column has even x, so it only lands in h.
            if (!x_q[0]) begin
                h_d = din;
            end else if (!y_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d     = r_w;
                out_vld_d = 1'b1;
                fd_d      = (x_q == X_FD) && (y_q == Y_FD);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            h_q       <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            h_q       <= h_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            fd_q      <= fd_d;
        end
    end

    // Row 0 of every frame rewrites each slot before odd rows read it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= p_w;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_vld_q;
    assign frame_done     = fd_q;

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Parametrised 2x2 stride-2 pooling stage for raster-scanned CNN feature maps. It processes CH channels in parallel, one pixel per valid cycle, and supports max or average mode with signed or unsigned data. Arbitrary (including odd) frame dimensions are supported. It sits between a convolution/activation stage and the next conv or FC stage, and replaces the fixed 26x26, 3-channel, max-only pooling stage.

## Interface
- DATA_W, 32, bits per channel sample
- CH, 3, channels carried in parallel on the bus
- IMG_W, 26, input frame width in pixels (>=2)
- IMG_H, 26, input frame height in pixels (>=2)
- SIGNED, 1, 1 = two's-complement compare/sum, 0 = unsigned
- MODE, 0, 0 = max pooling, 1 = average pooling
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- data_in  input  CH*DATA_W  pixel; channel k at bits [(k+1)*DATA_W-1 : k*DATA_W]
- data_in_valid  input  1  pixel present this cycle
- data_out  output  CH*DATA_W  pooled pixel, same channel packing
- data_out_valid  output  1  data_out valid, single-cycle pulse per pooled pixel
- frame_done  output  1  pulse coincident with the last pooled pixel of a frame

## Operation
- Counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on data_in_valid.
  - x wraps to 0 after IMG_W-1, incrementing y.
  - y wraps to 0 after IMG_H-1, so the next frame starts at (0,0).
  - Counter widths are $clog2 of the dimension.
- Gaps in data_in_valid are allowed: all state holds. There is no backpressure.
- Horizontal stage, per channel:
  - On valid with even x, latch the sample into the hold register h.
  - On valid with odd x, form p = op(h, data_in).
- Vertical stage:
  - On odd x with even y, write p into the line buffer at index x>>1.
  - The line buffer depth is IMG_W/2. It is a register array or inferred RAM, and its contents are not reset.
  - On odd x with odd y, form r = op(lb[x>>1], p) and register it to data_out with data_out_valid=1.
- op in max mode: the larger operand, compared signed if SIGNED=1 and unsigned otherwise.
- op in avg mode:
  - p is the full-precision sum (DATA_W+1 bits).
  - The line buffer stores DATA_W+1 bits.
  - r is the DATA_W+2-bit sum of 4 samples. The output is r shifted right by 2 (arithmetic if SIGNED, i.e. floor), truncated to DATA_W.
  - No overflow is possible.
- Odd dimensions:
  - If IMG_W is odd, column IMG_W-1 is consumed (counters advance) but produces nothing.
  - If IMG_H is odd, row IMG_H-1 is consumed but produces nothing.
- Outputs per frame: (IMG_W/2)*(IMG_H/2), which is 169 at the defaults.
- frame_done=1 together with data_out_valid for the pooled pixel at (x=2*(IMG_W/2)-1, y=2*(IMG_H/2)-1).
- Reset (asserted at any time, including mid-frame):
  - x, y, h, data_out and data_out_valid clear to 0; frame_done clears to 0.
  - The first valid pixel after release is treated as (0,0).
  - Stale line-buffer data is never read, because row 0 always rewrites it first.

## Timing
- Latency is 1 cycle. data_out_valid rises in the cycle after the clock edge that accepts the odd-x, odd-y pixel.
- data_out holds its value until the next output event; it is only meaningful while valid=1.
- Throughput is one input per cycle, sustained.
- The maximum output rate is one pulse per 2 input cycles, so data_out_valid is never high in two consecutive cycles at full rate.
- Back-to-back frames have no dead cycle: pixel (0,0) of frame n+1 may follow the last pixel of frame n directly.
- Channels are independent. There is no cross-channel arithmetic.

## Test plan
- **Max, unsigned:** MODE=0, SIGNED=0, IMG_W=IMG_H=4, CH=1, continuous valid, pixel=y*4+x.
  - Required: outputs 5, 7, 13, 15, each 1 cycle after input pixels 5, 7, 13, 15.
  - Required: frame_done with 15 only.
- **Avg, same frame:** MODE=1, same 4x4 ramp.
  - Required: outputs 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5).
- **Signed window:** SIGNED=1, 2x2 frame {-5,-3,-8,-1}.
  - Required (max): -1.
  - Required (avg): sum -17, output -5.
  - Required (max, unsigned build): 0xFFFFFFFF.
- **Odd dimensions:** IMG_W=IMG_H=5, ramp pixel=y*5+x.
  - Required: exactly 4 outputs (max mode 6, 8, 16, 18).
  - Required: column 4 and row 4 produce nothing.
  - Required: the next frame's first output is again 6.
- **Valid gaps and channels:** 4x4 ramp with valid toggling randomly (~50%), CH=3, channel k = pixel+100k.
  - Required: the same 4 outputs per channel as the gap-free case, plus offsets 0/100/200.
- **Reset mid-frame:** assert rst_n after 6 pixels, release, then send a full 4x4 frame.
  - Required: data_out and data_out_valid are 0 during reset.
  - Required: the post-reset frame yields exactly 5, 7, 13, 15 with frame_done on 15.
